// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - datapath-facing control and status bundle for the multicycle controller
interface control_unit_if;
   logic [31:0] instruction;
   logic [3:0]  aluCarryFlags;
   logic        ramMFC;
   logic        hardwareInterrupt;
   logic        maskableInterrupt;
   logic        signExtend;
   logic        clearPC;
   logic        regFileRW;
   logic [4:0]  regFileRD;
   logic [4:0]  regFileRS;
   logic [4:0]  regFileRT;
   logic [1:0]  aluSign;
   logic [3:0]  aluOperation;
   logic [1:0]  ramDataSize;
   logic        ramMFA;
   logic        ramRW;
   logic [8:0]  ramAddress;
   logic        regFileEnable;
   logic        pcEnable;
   logic        irEnable;
   logic        marEnable;
   logic        mdrEnable;
   logic [1:0]  muxSignals;
   logic        muxSignals2;
   logic        muxSignals3;
   logic        muxSignals4;

   modport master (
      input  instruction, aluCarryFlags, ramMFC, hardwareInterrupt, maskableInterrupt,
      output signExtend, clearPC, regFileRW, regFileRD, regFileRS, regFileRT, aluSign,
             aluOperation, ramDataSize, ramMFA, ramRW, ramAddress, regFileEnable, pcEnable,
             irEnable, marEnable, mdrEnable, muxSignals, muxSignals2, muxSignals3, muxSignals4
   );

   modport slave (
      output instruction, aluCarryFlags, ramMFC, hardwareInterrupt, maskableInterrupt,
      input  signExtend, clearPC, regFileRW, regFileRD, regFileRS, regFileRT, aluSign,
             aluOperation, ramDataSize, ramMFA, ramRW, ramAddress, regFileEnable, pcEnable,
             irEnable, marEnable, mdrEnable, muxSignals, muxSignals2, muxSignals3, muxSignals4
   );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore multicycle controller sequencing fetch/decode/execute/memory/writeback
module control_unit (
   input  logic          Clk,
   input  logic          reset,
   control_unit_if.master cu
);
   typedef enum logic [3:0] {
      S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE, S_R_EX, S_I_EX, S_MEM_ADDR,
      S_LOAD1, S_LOAD2, S_STORE0, S_STORE1, S_BRANCH, S_BRTAKE, S_INT
   } state_t;

   state_t state_q, state_d;
   logic   mask_q, mask_d;

   logic [5:0] opcode, funct;
   logic [3:0] r_op, i_op;
   logic       r_valid, r_signed, r_hilo, i_valid, i_signed, i_sext;
   logic       is_mem, is_store, is_branch, load_sext;
   logic [1:0] mem_size;
   logic       unused_ok;

   assign opcode    = cu.instruction[31:26];
   assign funct     = cu.instruction[5:0];
   assign is_mem    = (opcode[5:4] == 2'b10) && (opcode[3:2] != 2'b11);
   assign is_store  = (opcode[5:3] == 3'b101);
   assign is_branch = (opcode == 6'b000100) || (opcode == 6'b000101);
   assign mem_size  = opcode[1] ? 2'b10 : {1'b0, opcode[0]};
   assign load_sext = ~opcode[2] & ~opcode[1];
   assign unused_ok = ^{cu.instruction[10:6], cu.aluCarryFlags[2:0]};

   assign cu.regFileRS  = cu.instruction[25:21];
   assign cu.regFileRT  = cu.instruction[20:16];
   assign cu.regFileRD  = (opcode == 6'b000000) ? cu.instruction[15:11] : cu.instruction[20:16];
   assign cu.ramAddress = {5'b0, state_q};

   always_comb begin
      r_op = 4'b0000; r_valid = 1'b1; r_signed = 1'b0; r_hilo = 1'b0;
      unique case (funct)
         6'b100000: begin r_op = 4'b0000; r_signed = 1'b1; end
         6'b100001: r_op = 4'b0000;
         6'b100010: begin r_op = 4'b0001; r_signed = 1'b1; end
         6'b100011: r_op = 4'b0001;
         6'b100100: r_op = 4'b0010;
         6'b100101: r_op = 4'b0011;
         6'b100110: r_op = 4'b0100;
         6'b100111: r_op = 4'b0101;
         6'b101010: begin r_op = 4'b0110; r_signed = 1'b1; end
         6'b101011: r_op = 4'b0110;
         6'b000000: r_op = 4'b0111;
         6'b000010: r_op = 4'b1000;
         6'b000011: begin r_op = 4'b1001; r_signed = 1'b1; end
         6'b011000: begin r_op = 4'b1010; r_signed = 1'b1; r_hilo = 1'b1; end
         6'b011010: begin r_op = 4'b1011; r_signed = 1'b1; r_hilo = 1'b1; end
         default:   r_valid = 1'b0;
      endcase
   end

   always_comb begin
      i_op = 4'b0000; i_valid = 1'b1; i_signed = 1'b0; i_sext = 1'b0;
      unique case (opcode)
         6'b001000: begin i_op = 4'b0000; i_signed = 1'b1; i_sext = 1'b1; end
         6'b001001: begin i_op = 4'b0000; i_sext = 1'b1; end
         6'b001010: begin i_op = 4'b0110; i_signed = 1'b1; i_sext = 1'b1; end
         6'b001100: i_op = 4'b0010;
         6'b001101: i_op = 4'b0011;
         6'b001110: i_op = 4'b0100;
         6'b001111: i_op = 4'b1100;
         default:   i_valid = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RESET;
         mask_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q | (state_q == S_INT);
      unique case (state_q)
         S_RESET:  state_d = S_FETCH0;
         S_FETCH0: state_d = (cu.hardwareInterrupt || (cu.maskableInterrupt && !mask_q)) ? S_INT : S_FETCH1;
         S_FETCH1: state_d = cu.ramMFC ? S_FETCH2 : S_FETCH1;
         S_FETCH2: state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == 6'b000000) state_d = r_valid ? S_R_EX : S_FETCH0;
            else if (i_valid)        state_d = S_I_EX;
            else if (is_mem)         state_d = S_MEM_ADDR;
            else if (is_branch)      state_d = S_BRANCH;
            else                     state_d = S_FETCH0;
         end
         S_MEM_ADDR: state_d = is_store ? S_STORE0 : S_LOAD1;
         S_LOAD1:    state_d = cu.ramMFC ? S_LOAD2 : S_LOAD1;
         S_STORE0:   state_d = S_STORE1;
         S_STORE1:   state_d = cu.ramMFC ? S_FETCH0 : S_STORE1;
         // opcode[0] distinguishes bne from beq; flag bit 3 is Z
         S_BRANCH:   state_d = (opcode[0] ^ cu.aluCarryFlags[3]) ? S_BRTAKE : S_FETCH0;
         default:    state_d = S_FETCH0;
      endcase
   end

   always_comb begin
      cu.signExtend = 1'b0; cu.clearPC = 1'b0; cu.regFileRW = 1'b0; cu.aluSign = 2'b00;
      cu.aluOperation = 4'b0000; cu.ramDataSize = 2'b00; cu.ramMFA = 1'b0; cu.ramRW = 1'b0;
      cu.regFileEnable = 1'b0; cu.pcEnable = 1'b0; cu.irEnable = 1'b0; cu.marEnable = 1'b0;
      cu.mdrEnable = 1'b0; cu.muxSignals = 2'b00; cu.muxSignals2 = 1'b0; cu.muxSignals3 = 1'b0;
      cu.muxSignals4 = 1'b0;
      unique case (state_q)
         S_RESET:  cu.clearPC = 1'b1;
         S_FETCH0: cu.marEnable = 1'b1;
         S_FETCH1: begin
            cu.ramMFA = 1'b1; cu.ramRW = 1'b1; cu.ramDataSize = 2'b10; cu.mdrEnable = 1'b1;
         end
         S_FETCH2: begin cu.irEnable = 1'b1; cu.pcEnable = 1'b1; end
         S_R_EX: begin
            cu.aluOperation = r_op; cu.aluSign = {1'b0, r_signed};
            cu.regFileEnable = 1'b1; cu.regFileRW = ~r_hilo; cu.muxSignals3 = r_hilo;
         end
         S_I_EX: begin
            cu.aluOperation = i_op; cu.aluSign = {1'b0, i_signed}; cu.muxSignals = 2'b01;
            cu.muxSignals4 = i_sext; cu.regFileEnable = 1'b1; cu.regFileRW = 1'b1;
         end
         S_MEM_ADDR: begin cu.muxSignals = 2'b01; cu.muxSignals4 = 1'b1; cu.marEnable = 1'b1; end
         S_LOAD1: begin
            cu.ramMFA = 1'b1; cu.ramRW = 1'b1; cu.mdrEnable = 1'b1;
            cu.ramDataSize = mem_size; cu.signExtend = load_sext;
         end
         S_LOAD2: begin
            cu.aluOperation = 4'b1101; cu.muxSignals = 2'b11; cu.regFileEnable = 1'b1; cu.regFileRW = 1'b1;
         end
         S_STORE0: begin cu.aluOperation = 4'b1101; cu.muxSignals2 = 1'b1; cu.mdrEnable = 1'b1; end
         S_STORE1: begin cu.ramMFA = 1'b1; cu.ramDataSize = mem_size; end
         S_BRANCH: begin cu.aluOperation = 4'b0001; cu.aluSign = 2'b01; end
         S_BRTAKE: begin cu.pcEnable = 1'b1; cu.muxSignals4 = 1'b1; end
         S_INT:    cu.clearPC = 1'b1;
         default:  ;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed table-driven bench for control_unit
module tb_control_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   control_unit_if cu_if ();
   control_unit dut (.Clk(clk), .reset(reset), .cu(cu_if.master));

   localparam logic [22:0] C_SE  = 23'h1 << 22;
   localparam logic [22:0] C_CLR = 23'h1 << 21;
   localparam logic [22:0] C_RW  = 23'h1 << 20;
   localparam logic [22:0] C_MFA = 23'h1 << 11;
   localparam logic [22:0] C_RRD = 23'h1 << 10;
   localparam logic [22:0] C_REN = 23'h1 << 9;
   localparam logic [22:0] C_PC  = 23'h1 << 8;
   localparam logic [22:0] C_IR  = 23'h1 << 7;
   localparam logic [22:0] C_MAR = 23'h1 << 6;
   localparam logic [22:0] C_MDR = 23'h1 << 5;
   localparam logic [22:0] C_MS2 = 23'h1 << 2;
   localparam logic [22:0] C_MS3 = 23'h1 << 1;
   localparam logic [22:0] C_MS4 = 23'h1;

   function automatic logic [22:0] ctl(logic [1:0] sg, logic [3:0] op, logic [1:0] sz,
                                       logic [1:0] mx, logic [22:0] b);
      return b | {3'b0, sg, op, sz, 7'b0, mx, 3'b0};
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [14:0] regs;
      logic [3:0]  flags;
      logic        mfc, hw, mi;
      logic [3:0]  st;
      logic [22:0] c;
   } rec_t;

   rec_t        tbl[$];
   logic [31:0] cur_instr;
   logic [14:0] cur_regs;
   int          n_pass = 0;
   int          n_total = 0;

   logic [22:0] act_ctl;
   logic [14:0] act_regs;
   assign act_ctl = {cu_if.signExtend, cu_if.clearPC, cu_if.regFileRW, cu_if.aluSign,
                     cu_if.aluOperation, cu_if.ramDataSize, cu_if.ramMFA, cu_if.ramRW,
                     cu_if.regFileEnable, cu_if.pcEnable, cu_if.irEnable, cu_if.marEnable,
                     cu_if.mdrEnable, cu_if.muxSignals, cu_if.muxSignals2, cu_if.muxSignals3,
                     cu_if.muxSignals4};
   assign act_regs = {cu_if.regFileRS, cu_if.regFileRT, cu_if.regFileRD};

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic use_instr(logic [31:0] i, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      cur_instr = i;
      cur_regs  = {rs, rt, rd};
   endtask

   task automatic add(logic mfc, logic hw, logic mi, logic [3:0] flags, logic [3:0] st, logic [22:0] c);
      rec_t r;
      r.instr = cur_instr; r.regs = cur_regs; r.flags = flags;
      r.mfc = mfc; r.hw = hw; r.mi = mi; r.st = st; r.c = c;
      tbl.push_back(r);
   endtask

   task automatic apply(logic [31:0] i, logic [3:0] f, logic mfc, logic hw, logic mi);
      cu_if.instruction = i; cu_if.aluCarryFlags = f; cu_if.ramMFC = mfc;
      cu_if.hardwareInterrupt = hw; cu_if.maskableInterrupt = mi;
   endtask

   task automatic fetch(logic mfc);
      add(mfc, 0, 0, 4'b0000, 4'd2, ctl(2'b00, 4'b0000, 2'b10, 2'b00, C_MFA | C_RRD | C_MDR));
      add(mfc, 0, 0, 4'b0000, 4'd3, C_IR | C_PC);
      add(mfc, 0, 0, 4'b0000, 4'd4, 23'h0);
   endtask

   initial begin
      logic [22:0] f1, mema;
      f1   = C_MAR;
      mema = ctl(2'b00, 4'b0000, 2'b00, 2'b01, C_MAR | C_MS4);

      use_instr(32'h00221820, 5'd1, 5'd2, 5'd3);
      add(0, 0, 0, 4'b0000, 4'd1, f1);
      add(0, 0, 0, 4'b0000, 4'd2, ctl(2'b00, 4'b0000, 2'b10, 2'b00, C_MFA | C_RRD | C_MDR));
      add(0, 0, 0, 4'b0000, 4'd2, ctl(2'b00, 4'b0000, 2'b10, 2'b00, C_MFA | C_RRD | C_MDR));
      add(0, 0, 0, 4'b0000, 4'd2, ctl(2'b00, 4'b0000, 2'b10, 2'b00, C_MFA | C_RRD | C_MDR));
      add(1, 0, 0, 4'b0000, 4'd3, C_IR | C_PC);
      add(0, 0, 0, 4'b0000, 4'd4, 23'h0);
      add(0, 0, 0, 4'b0000, 4'd5, ctl(2'b01, 4'b0000, 2'b00, 2'b00, C_REN | C_RW));
      add(0, 0, 0, 4'b0000, 4'd1, f1);

      use_instr(32'h82000000, 5'd16, 5'd0, 5'd0);
      fetch(1);
      add(0, 0, 0, 4'b0000, 4'd7, mema);
      add(0, 0, 0, 4'b0000, 4'd8, ctl(2'b00, 4'b0000, 2'b00, 2'b00, C_MFA | C_RRD | C_MDR | C_SE));
      add(1, 0, 0, 4'b0000, 4'd9, ctl(2'b00, 4'b1101, 2'b00, 2'b11, C_REN | C_RW));
      add(1, 0, 0, 4'b0000, 4'd1, f1);

      use_instr(32'hACC50004, 5'd6, 5'd5, 5'd5);
      fetch(1);
      add(1, 0, 0, 4'b0000, 4'd7, mema);
      add(1, 0, 0, 4'b0000, 4'd10, ctl(2'b00, 4'b1101, 2'b00, 2'b00, C_MS2 | C_MDR));
      add(1, 0, 0, 4'b0000, 4'd11, ctl(2'b00, 4'b0000, 2'b10, 2'b00, C_MFA));
      add(1, 0, 0, 4'b0000, 4'd1, f1);

      use_instr(32'h10220008, 5'd1, 5'd2, 5'd2);
      fetch(1);
      add(1, 0, 0, 4'b1000, 4'd12, ctl(2'b01, 4'b0001, 2'b00, 2'b00, 23'h0));
      add(1, 0, 0, 4'b1000, 4'd13, C_PC | C_MS4);
      add(1, 0, 0, 4'b0000, 4'd1, f1);
      fetch(1);
      add(1, 0, 0, 4'b0000, 4'd12, ctl(2'b01, 4'b0001, 2'b00, 2'b00, 23'h0));
      add(1, 0, 0, 4'b0000, 4'd1, f1);

      use_instr(32'h34E400FF, 5'd7, 5'd4, 5'd4);
      fetch(1);
      add(1, 0, 0, 4'b0000, 4'd6, ctl(2'b00, 4'b0011, 2'b00, 2'b01, C_REN | C_RW));
      add(1, 0, 0, 4'b0000, 4'd1, f1);

      use_instr(32'h00220018, 5'd1, 5'd2, 5'd0);
      fetch(1);
      add(1, 0, 0, 4'b0000, 4'd5, ctl(2'b01, 4'b1010, 2'b00, 2'b00, C_REN | C_MS3));
      add(1, 0, 0, 4'b0000, 4'd1, f1);

      use_instr(32'h08000000, 5'd0, 5'd0, 5'd0);
      fetch(1);
      add(1, 0, 0, 4'b0000, 4'd1, f1);
      add(1, 0, 1, 4'b0000, 4'd14, C_CLR);
      add(1, 0, 0, 4'b0000, 4'd1, f1);
      fetch(1);
      add(1, 0, 1, 4'b0000, 4'd1, f1);
      add(1, 1, 0, 4'b0000, 4'd14, C_CLR);
      add(1, 0, 0, 4'b0000, 4'd1, f1);

      apply(32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
      #1;
      chk("reset_addr", {23'b0, cu_if.ramAddress}, 32'd0);
      chk("reset_ctl", {9'b0, act_ctl}, {9'b0, C_CLR});
      chk("reset_regs", {17'b0, act_regs}, 32'd0);

      @(negedge clk);
      reset = 1'b0;
      foreach (tbl[k]) begin
         apply(tbl[k].instr, tbl[k].flags, tbl[k].mfc, tbl[k].hw, tbl[k].mi);
         @(posedge clk);
         #1;
         chk($sformatf("step%0d_state", k), {23'b0, cu_if.ramAddress}, {28'b0, tbl[k].st});
         chk($sformatf("step%0d_ctl", k), {9'b0, act_ctl}, {9'b0, tbl[k].c});
         chk($sformatf("step%0d_regs", k), {17'b0, act_regs}, {17'b0, tbl[k].regs});
         @(negedge clk);
      end

      apply(32'h08000000, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("midacc_state", {23'b0, cu_if.ramAddress}, 32'd2);
      chk("midacc_mfa", {31'b0, cu_if.ramMFA}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_drop_mfa", {31'b0, cu_if.ramMFA}, 32'd0);
      chk("rst_drop_addr", {23'b0, cu_if.ramAddress}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("both_pre", {23'b0, cu_if.ramAddress}, 32'd1);
      @(negedge clk);
      apply(32'h08000000, 4'b0000, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk("both_int", {23'b0, cu_if.ramAddress}, 32'd14);
      @(negedge clk);
      apply(32'h08000000, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("both_ret", {23'b0, cu_if.ramAddress}, 32'd1);
      @(posedge clk); #1;
      chk("both_single", {23'b0, cu_if.ramAddress}, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
